// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift unit.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SEL_SHAMT   = 2'b00,
        SEL_CONST   = 2'b01,
        SEL_REGB    = 2'b10,
        SEL_ILLEGAL = 2'b11
    } amt_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int SHAMT_LSB = 6;

endpackage

// File: rtl/shift_amt_sel.sv
// Shift-amount source mux: shamt field, constant or register B.
module shift_amt_sel
    import shift_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int AMT_W     = $clog2(DATA_W),
    parameter int CONST_AMT = 16
) (
    input  logic [1:0]        amt_sel,
    input  logic [15:0]       offset,
    input  logic [DATA_W-1:0] reg_b,
    output logic [AMT_W-1:0]  amt,
    output logic              illegal
);

    localparam int CONST_MOD = CONST_AMT % DATA_W;
    localparam logic [AMT_W-1:0] CAMT = CONST_MOD[AMT_W-1:0];

    // only a slice of each source feeds the mux
    logic unused_bits;
    assign unused_bits = ^{offset, reg_b};

    always_comb begin
        amt     = '0;
        illegal = 1'b0;
        unique case (amt_sel_e'(amt_sel))
            SEL_SHAMT: amt = offset[SHAMT_LSB +: AMT_W];
            SEL_CONST: amt = CAMT;
            SEL_REGB:  amt = reg_b[AMT_W-1:0];
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shifter: SHIFT_PER_CYCLE positions per cycle, start/busy/done.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int AMT_W           = $clog2(DATA_W),
    parameter int CONST_AMT       = 16,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        amt_sel,
    input  logic [15:0]       offset,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [AMT_W-1:0]  amt_used
);

    localparam logic [AMT_W:0]   SPC_W = (AMT_W+1)'(SHIFT_PER_CYCLE);
    localparam logic [AMT_W-1:0] SPC_A = AMT_W'(SHIFT_PER_CYCLE);
    localparam logic [AMT_W:0]   DW    = (AMT_W+1)'(DATA_W);

    state_e            state;
    mode_e             mode_q;
    logic [DATA_W-1:0] work;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  sel_amt;
    logic              illegal;
    logic              accept;
    logic [AMT_W-1:0]  k;
    logic [AMT_W-1:0]  rem_nxt;
    logic [AMT_W:0]    rsh;
    logic [DATA_W-1:0] nxt;

    shift_amt_sel #(
        .DATA_W    (DATA_W),
        .AMT_W     (AMT_W),
        .CONST_AMT (CONST_AMT)
    ) u_sel (
        .amt_sel (amt_sel),
        .offset  (offset),
        .reg_b   (reg_b),
        .amt     (sel_amt),
        .illegal (illegal)
    );

    assign accept = start && (state != ST_SHIFT);

    // k = min(rem, SHIFT_PER_CYCLE); rotate left-part uses DATA_W-k
    always_comb begin
        k = rem;
        if ({1'b0, rem} > SPC_W)
            k = SPC_A;
        rem_nxt = rem - k;
        rsh     = DW - {1'b0, k};
        nxt     = work;
        unique case (mode_q)
            MODE_SLL: nxt = work << k;
            MODE_SRL: nxt = work >> k;
            MODE_SRA: nxt = $signed(work) >>> k;
            MODE_ROR: nxt = (work >> k) | (work << rsh);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SLL;
            work     <= '0;
            rem      <= '0;
            result   <= '0;
            amt_used <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            if (accept && illegal) begin
                err   <= 1'b1;
                state <= ST_IDLE;
            end else if (accept) begin
                work     <= data_in;
                mode_q   <= mode_e'(mode);
                amt_used <= sel_amt;
                rem      <= sel_amt;
                if (sel_amt == '0) begin
                    state  <= ST_DONE;
                    done   <= 1'b1;
                    result <= data_in;
                end else begin
                    state <= ST_SHIFT;
                    busy  <= 1'b1;
                end
            end else if (state == ST_SHIFT) begin
                work <= nxt;
                rem  <= rem_nxt;
                if (rem_nxt == '0) begin
                    state  <= ST_DONE;
                    done   <= 1'b1;
                    result <= nxt;
                end else begin
                    busy <= 1'b1;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq; two instances (1 and 4 bits/cycle).
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  amt_sel;
    logic [15:0] offset;
    logic [31:0] reg_b;
    logic [31:0] data_in;

    logic        b0, d0, e0, b1, d1, e1;
    logic [31:0] r0, r1;
    logic [4:0]  a0, a1;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int cnt0  = 0;
    int cnt1  = 0;
    int f0    = -1;
    int f1    = -1;
    int t0    = 0;
    int c0    = 0;
    int c1    = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.SHIFT_PER_CYCLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .amt_sel(amt_sel), .offset(offset), .reg_b(reg_b),
        .data_in(data_in), .busy(b0), .done(d0), .err(e0),
        .result(r0), .amt_used(a0)
    );

    shift_unit_seq #(.SHIFT_PER_CYCLE(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .amt_sel(amt_sel), .offset(offset), .reg_b(reg_b),
        .data_in(data_in), .busy(b1), .done(d1), .err(e1),
        .result(r1), .amt_used(a1)
    );

    always @(negedge clk) begin
        ncyc++;
        if (d0) begin
            cnt0++;
            if (f0 < 0) f0 = ncyc;
        end
        if (d1) begin
            cnt1++;
            if (f1 < 0) f1 = ncyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [1:0] s,
                          input logic [15:0] off, input logic [31:0] rb,
                          input logic [31:0] din, input bit hold);
        @(negedge clk); #1;
        mode = m; amt_sel = s; offset = off; reg_b = rb; data_in = din;
        start = 1'b1;
        f0 = -1; f1 = -1; t0 = ncyc;
        @(posedge clk); #1;
        if (hold) begin
            data_in = 32'hFFFF_FFFF; mode = 2'b00;
            amt_sel = 2'b10; reg_b = 32'd1;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && (f0 < 0 || f1 < 0); i++) begin
            @(negedge clk); #1;
        end
        if (f0 < 0 || f1 < 0)
            check({tag, "_timeout"}, 64'(f0 < 0 || f1 < 0), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = '0; amt_sel = '0;
        offset = '0; reg_b = '0; data_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_result", r0, 0);
        check("rst_amt", a0, 0);
        check("rst_busy", b0, 0);
        check("rst_done", d0, 0);
        check("rst_err", e0, 0);
        @(negedge clk); reset = 1'b1;

        // SLL by shamt 5
        run_op(2'b00, 2'b00, 16'h0140, 32'h0, 32'h0000_0001, 1'b0);
        wait_done("sll");
        check("sll_res0", r0, 32'h0000_0020);
        check("sll_res1", r1, 32'h0000_0020);
        check("sll_amt", a0, 5);
        check("sll_lat0", f0 - t0, 6);
        check("sll_lat1", f1 - t0, 3);

        // SRA by constant 16
        run_op(2'b10, 2'b01, 16'h0, 32'h0, 32'h8000_0000, 1'b0);
        wait_done("sra");
        check("sra_res0", r0, 32'hFFFF_8000);
        check("sra_res1", r1, 32'hFFFF_8000);
        check("sra_amt", a0, 16);
        check("sra_lat0", f0 - t0, 17);
        check("sra_lat1", f1 - t0, 5);

        // ROR by reg_b with a start held into the busy cycle
        run_op(2'b11, 2'b10, 16'h0, 32'h0000_0024, 32'h1234_5678, 1'b1);
        wait_done("ror");
        check("ror_res0", r0, 32'h8123_4567);
        check("ror_res1", r1, 32'h8123_4567);
        check("ror_amt", a0, 4);
        check("ror_lat0", f0 - t0, 5);
        check("ror_lat1", f1 - t0, 2);
        repeat (3) @(negedge clk);
        #1;
        check("ror_noreq_busy", b0, 0);
        check("ror_noreq_res", r0, 32'h8123_4567);

        // zero amount then back-to-back accept in the DONE cycle
        @(negedge clk); #1;
        mode = 2'b01; amt_sel = 2'b10; reg_b = 32'h20;
        data_in = 32'hCAFE_BABE; start = 1'b1;
        t0 = ncyc; f0 = -1; f1 = -1; c0 = cnt0;
        @(posedge clk); #1;
        mode = 2'b00; reg_b = 32'd1; data_in = 32'd3;
        @(negedge clk); #1;
        check("z_done0", d0, 1);
        check("z_res0", r0, 32'hCAFE_BABE);
        check("z_res1", r1, 32'hCAFE_BABE);
        check("z_lat0", f0 - t0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check("b2b_busy", b0, 1);
        check("b2b_nodone", d0, 0);
        @(negedge clk); #1;
        check("b2b_done0", d0, 1);
        check("b2b_done1", d1, 1);
        check("b2b_res0", r0, 32'd6);
        check("b2b_res1", r1, 32'd6);
        check("b2b_cnt", cnt0 - c0, 2);

        // illegal select
        run_op(2'b00, 2'b11, 16'h0, 32'h0, 32'h1234_5678, 1'b0);
        @(negedge clk); #1;
        check("ill_err0", e0, 1);
        check("ill_err1", e1, 1);
        check("ill_busy", b0, 0);
        check("ill_res", r0, 32'd6);
        check("ill_amt", a0, 1);
        @(negedge clk); #1;
        check("ill_err_pulse", e0, 0);

        // reset in the middle of a 20-position shift
        run_op(2'b00, 2'b10, 16'h0, 32'd20, 32'd1, 1'b0);
        c0 = cnt0; c1 = cnt1;
        repeat (2) @(negedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("mid_res", r0, 0);
        check("mid_amt", a0, 0);
        check("mid_busy0", b0, 0);
        check("mid_busy1", b1, 0);
        check("mid_done", d0, 0);
        check("mid_err", e0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("mid_nodone0", cnt0 - c0, 0);
        check("mid_nodone1", cnt1 - c1, 0);
        @(negedge clk); reset = 1'b1;

        run_op(2'b00, 2'b00, 16'h00C0, 32'h0, 32'h0000_000F, 1'b0);
        wait_done("post");
        check("post_res0", r0, 32'h78);
        check("post_res1", r1, 32'h78);
        check("post_lat0", f0 - t0, 4);
        check("post_lat1", f1 - t0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised multi-cycle shifter for the multicycle datapath; generalises the shift-amount source mux into a complete shift unit. Selects the shift amount from one of three sources (instruction shamt field, constant, register B), latches the operand and shifts it iteratively, SHIFT_PER_CYCLE positions per cycle. Adds rotate-right and arithmetic modes, a start/busy/done handshake and an illegal-select error flag. Sits between the register file/B latch and the ALU-out/writeback mux; driven by the control FSM.

Parameters:
DATA_W, 32, operand width; power of two, 8..64
AMT_W, $clog2(DATA_W), shift-amount width (derived; do not override)
CONST_AMT, 16, constant amount for amt_sel=01; used modulo DATA_W
SHIFT_PER_CYCLE, 1, maximum positions shifted per SHIFT cycle; 1..DATA_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled on accept only
mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
amt_sel  in  2  00 offset shamt, 01 CONST_AMT, 10 reg_b, 11 illegal
offset  in  16  instruction immediate; shamt = offset[6+AMT_W-1:6]
reg_b  in  DATA_W  register B; amount = reg_b[AMT_W-1:0]
data_in  in  DATA_W  operand to shift
busy  out  1  high in SHIFT state
done  out  1  one-cycle pulse, result valid
err  out  1  one-cycle pulse on illegal amt_sel
result  out  DATA_W  shifted value; held until next accept
amt_used  out  AMT_W  amount latched at accept

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; result=0, amt_used=0, busy=0, done=0, err=0. Reset mid-SHIFT aborts the operation; no done is issued.
- States: IDLE, SHIFT, DONE. Accept = start && state in {IDLE, DONE}; start while in SHIFT is ignored (not queued).
- On accept with amt_sel!=11: latch data_in into the working register, latch mode, amt_used=selected amount, rem=amt_used. rem==0 -> DONE, otherwise -> SHIFT.
- On accept with amt_sel==11: err=1 for that following cycle, state -> IDLE, result/amt_used unchanged.
- SHIFT: each cycle shift the working register by k=min(rem, SHIFT_PER_CYCLE); rem-=k; rem reaching 0 -> DONE.
- DONE: done=1 for exactly one cycle; result = working register. Next state IDLE, or SHIFT/DONE if a new accept occurs in the same cycle (back-to-back; result updates at the next done).
- Latency: accept at edge T -> done high in cycle T+1+ceil(amt/SHIFT_PER_CYCLE).
- Arithmetic: SLL/SRL fill with zeros; SRA fills with the operand MSB (sign); ROR feeds bits shifted out at bit 0 into the MSB. All amounts are modulo DATA_W (AMT_W bits), so amount 0 returns data_in unchanged in every mode.
- Inputs other than start are don't-care except on the accept cycle.
- busy and done are never high together; err never coincides with busy.

Decomposition:
- Package shift_pkg: mode encoding (SLL/SRL/SRA/ROR), amt_sel encoding (SHAMT/CONST/REGB/ILLEGAL), state encoding (IDLE/SHIFT/DONE), SHAMT_LSB=6.
- Sub-module shift_amt_sel: combinational amount mux (amt_sel, offset, reg_b, CONST_AMT) -> amount + illegal flag.
- Shift step and FSM stay in shift_unit_seq.

Test Plan:
- Reset mid-op: start SLL amt=20, deassert reset on cycle 3 -> all outputs 0, state IDLE, no done pulse; after release, the next start completes normally.
- SLL via shamt: data_in=0x0000_0001, offset=0x0140 (shamt=5), amt_sel=00, SPC=1 -> done at T+6, result=0x0000_0020, amt_used=5.
- SRA via constant: data_in=0x8000_0000, amt_sel=01 (16) -> result=0xFFFF_8000, done at T+17 for SPC=1 and at T+5 for SPC=4.
- ROR via reg_b: data_in=0x1234_5678, reg_b=0x0000_0024 (amount 4) -> result=0x8123_4567; start pulsed while busy is ignored.
- Zero amount/back-to-back: SRL with reg_b=0x20 (amount 0) -> done at T+1 with result=data_in; a second start in the DONE cycle is accepted without an IDLE gap.
- Illegal select: amt_sel=11 -> err pulse at T+1, busy=0, result unchanged from the previous op.
